// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bundle: redirect/stall controls and loader port in, registered instruction out.
// Handshake: the fetch unit has no ready input; instr_valid=1 marks a real word on the outputs.
// instr_valid=0 marks a bubble. stall is the only back-pressure and holds the outputs in place.
interface instruction_fetch_unit_if;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic        imem_we;
    logic [31:0] imem_waddr;
    logic [31:0] imem_wdata;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc_plus4;
    logic        instr_valid;
    logic        misalign_err;

    modport master (
        output stall, branch_taken, branch_target, jump, imem_we, imem_waddr, imem_wdata,
        input  instruction, instr_pc, instr_pc_plus4, instr_valid, misalign_err
    );

    modport slave (
        input  stall, branch_taken, branch_target, jump, imem_we, imem_waddr, imem_wdata,
        output instruction, instr_pc, instr_pc_plus4, instr_valid, misalign_err
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC register, word-addressed instruction memory and registered instruction
// output, with jump/branch redirect (one-cycle squash) and stall hold.
module instruction_fetch_unit #(
    parameter int          IMEM_DEPTH = 1024,
    parameter logic [31:0] PC_RESET   = 32'h0
) (
    input logic                     clk,
    input logic                     rst,
    instruction_fetch_unit_if.slave bus
);
    localparam int IDX_W = $clog2(IMEM_DEPTH);

    logic [31:0]      imem [IMEM_DEPTH];
    logic [31:0]      pc;
    logic [31:0]      instruction_q;
    logic [31:0]      instr_pc_q;
    logic [31:0]      instr_pc_plus4;
    logic [31:0]      jump_target;
    logic             instr_valid_q;
    logic             misalign_q;
    logic [IDX_W-1:0] fetch_idx;
    logic [IDX_W-1:0] write_idx;
    logic             unused_addr_bits;

    // Only the low index bits address memory, so fetch wraps every IMEM_DEPTH words.
    assign fetch_idx        = pc[IDX_W+1:2];
    assign write_idx        = bus.imem_waddr[IDX_W+1:2];
    assign unused_addr_bits = ^{bus.imem_waddr[1:0], bus.imem_waddr[31:IDX_W+2]};

    assign instr_pc_plus4 = instr_pc_q + 32'd4;
    assign jump_target    = {instr_pc_plus4[31:28], instruction_q[25:0], 2'b00};

    // Loader port is independent of reset; same-edge fetch sees the old word.
    always_ff @(posedge clk) begin
        if (bus.imem_we) begin
            imem[write_idx] <= bus.imem_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc            <= PC_RESET;
            instruction_q <= 32'h0;
            instr_pc_q    <= 32'h0;
            instr_valid_q <= 1'b0;
            misalign_q    <= 1'b0;
        end else if (bus.jump) begin
            pc            <= jump_target;
            instruction_q <= 32'h0;
            instr_valid_q <= 1'b0;
        end else if (bus.branch_taken) begin
            pc            <= {bus.branch_target[31:2], 2'b00};
            instruction_q <= 32'h0;
            instr_valid_q <= 1'b0;
            if (bus.branch_target[1:0] != 2'b00) begin
                misalign_q <= 1'b1;
            end
        end else if (!bus.stall) begin
            instruction_q <= imem[fetch_idx];
            instr_pc_q    <= pc;
            instr_valid_q <= 1'b1;
            pc            <= pc + 32'd4;
        end
    end

    assign bus.instruction    = instruction_q;
    assign bus.instr_pc       = instr_pc_q;
    assign bus.instr_pc_plus4 = instr_pc_plus4;
    assign bus.instr_valid    = instr_valid_q;
    assign bus.misalign_err   = misalign_q;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: each driven cycle pushes its expected outputs,
// and a negedge monitor pops and compares them against the DUT.
module tb_instruction_fetch_unit;
    localparam int W = 66; // {misalign, valid, instr_pc[31:0], instruction[31:0]}

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    logic [W-1:0] exp_q[$];

    instruction_fetch_unit_if bus ();

    instruction_fetch_unit #(
        .IMEM_DEPTH(1024),
        .PC_RESET  (32'h0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached, act=running req=finished");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: act=%08h req=%08h @%0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [W-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check32("instruction",    bus.instruction,            e[31:0]);
            check32("instr_pc",       bus.instr_pc,               e[63:32]);
            check32("instr_pc_plus4", bus.instr_pc_plus4,         e[63:32] + 32'd4);
            check32("instr_valid",    {31'h0, bus.instr_valid},   {31'h0, e[64]});
            check32("misalign_err",   {31'h0, bus.misalign_err},  {31'h0, e[65]});
        end
    end

    // ---------------- drivers ----------------
    function automatic logic [31:0] word_of(input int i);
        case (i)
            0:       word_of = 32'h014C7020;
            1:       word_of = 32'h0243F022;
            2:       word_of = 32'h01527024;
            3:       word_of = 32'h01527025;
            20:      word_of = 32'h08000010; // j with target field 0x10
            default: word_of = 32'h20000000 | 32'(i);
        endcase
    endfunction

    task automatic load(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        #1;
        rst            = 1'b0;
        bus.imem_we    = 1'b1;
        bus.imem_waddr = addr;
        bus.imem_wdata = data;
        exp_q.push_back({1'b0, 1'b0, 32'h0, 32'h0});
    endtask

    task automatic cyc(input logic s, input logic b, input logic j, input logic [31:0] tgt,
                       input logic [31:0] e_instr, input logic [31:0] e_pc,
                       input logic e_valid, input logic e_mis);
        @(negedge clk);
        #1;
        rst               = 1'b1;
        bus.imem_we       = 1'b0;
        bus.stall         = s;
        bus.branch_taken  = b;
        bus.jump          = j;
        bus.branch_target = tgt;
        exp_q.push_back({e_mis, e_valid, e_pc, e_instr});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_checks          = 0;
        n_fail            = 0;
        rst               = 1'b0;
        bus.stall         = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.jump          = 1'b0;
        bus.branch_target = 32'h0;
        bus.imem_we       = 1'b0;
        bus.imem_waddr    = 32'h0;
        bus.imem_wdata    = 32'h0;

        // Load the whole memory while held in reset; outputs must stay cleared.
        for (int i = 0; i < 1024; i++) load(32'(i) * 32'd4, word_of(i));

        // T1/T2: sequential fetch, then 3-cycle stall on the 2nd word
        cyc(0, 0, 0, 32'h0, 32'h014C7020, 32'h0, 1, 0);
        cyc(0, 0, 0, 32'h0, 32'h0243F022, 32'h4, 1, 0);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 32'h0, 32'h0243F022, 32'h4, 1, 0);
        cyc(0, 0, 0, 32'h0, 32'h01527024, 32'h8, 1, 0);
        cyc(0, 0, 0, 32'h0, 32'h01527025, 32'hC, 1, 0);

        // T3: branch with stall -> bubble, then word 16 at 0x40; run on to the j at 0x50
        cyc(1, 1, 0, 32'h40, 32'h0,          32'hC,  0, 0);
        cyc(0, 0, 0, 32'h0,  32'h20000010,   32'h40, 1, 0);
        cyc(0, 0, 0, 32'h0,  32'h20000011,   32'h44, 1, 0);
        cyc(0, 0, 0, 32'h0,  32'h20000012,   32'h48, 1, 0);
        cyc(0, 0, 0, 32'h0,  32'h20000013,   32'h4C, 1, 0);
        cyc(0, 0, 0, 32'h0,  32'h08000010,   32'h50, 1, 0);

        // T4: jump and branch together -> jump target 0x40 wins over 0x80
        cyc(0, 1, 1, 32'h80, 32'h0,          32'h50, 0, 0);
        cyc(0, 0, 0, 32'h0,  32'h20000010,   32'h40, 1, 0);
        cyc(0, 0, 0, 32'h0,  32'h20000011,   32'h44, 1, 0);

        // T5: misaligned branch target 0x42 -> fetch from 0x40, sticky error
        cyc(0, 1, 0, 32'h42, 32'h0,          32'h44, 0, 1);
        cyc(0, 0, 0, 32'h0,  32'h20000010,   32'h40, 1, 1);
        cyc(0, 0, 0, 32'h0,  32'h20000011,   32'h44, 1, 1);

        // T6: run past word 1023 -> pc 0x1000 returns word 0
        cyc(0, 1, 0, 32'hFF8, 32'h0,         32'h44,   0, 1);
        cyc(0, 0, 0, 32'h0,   32'h200003FE,  32'hFF8,  1, 1);
        cyc(0, 0, 0, 32'h0,   32'h200003FF,  32'hFFC,  1, 1);
        cyc(0, 0, 0, 32'h0,   32'h014C7020,  32'h1000, 1, 1);
        // Same-edge write to the index being fetched: old word comes out
        cyc(0, 0, 0, 32'h0,   32'h0243F022,  32'h1004, 1, 1);
        bus.imem_we    = 1'b1;
        bus.imem_waddr = 32'h0000_1007;
        bus.imem_wdata = 32'hDEADBEEF;

        // 32-bit pc wrap: 0xFFFFFFFC -> 0, and instr_pc_plus4 wraps to 0
        cyc(0, 1, 0, 32'hFFFFFFFC, 32'h0,        32'h1004,     0, 1);
        cyc(0, 0, 0, 32'h0,        32'h200003FF, 32'hFFFFFFFC, 1, 1);
        cyc(0, 0, 0, 32'h0,        32'h014C7020, 32'h0,        1, 1);
        cyc(0, 0, 0, 32'h0,        32'hDEADBEEF, 32'h4,        1, 1);

        // Mid-run reset clears outputs without waiting for a clock edge
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        check32("async_rst_valid",    {31'h0, bus.instr_valid},  32'h0);
        check32("async_rst_instr",    bus.instruction,           32'h0);
        check32("async_rst_pc",       bus.instr_pc,              32'h0);
        check32("async_rst_misalign", {31'h0, bus.misalign_err}, 32'h0);

        // First fetch after release is from PC_RESET
        cyc(0, 0, 0, 32'h0, 32'h014C7020, 32'h0, 1, 0);
        cyc(0, 0, 0, 32'h0, 32'hDEADBEEF, 32'h4, 1, 0);

        @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: act=%0d left req=0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
